// File: rtl/sht40_result_converter.sv
// SHT40 result converter: captures raw temperature/humidity words on the
// peripheral's ready-flag rising edges, converts them with a serial shift-add
// multiplier and presents one signed centi-degC / centi-%RH pair per
// measurement. CRC failures discard partial pairs and are counted.
//
// state  | meaning
// IDLE   | waiting for both have-flags
// MUL_T  | 16-cycle shift-add of the temperature word by 17500
// MUL_RH | 16-cycle shift-add of the humidity word by 12500
// FINAL  | clamp humidity, drive outputs, pulse result_valid
module sht40_result_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  input  logic [15:0] rh_raw,
  input  logic        temp_ready,
  input  logic        rh_ready,
  input  logic        crc_error,
  output logic [15:0] temp_centi,
  output logic [15:0] rh_centi,
  output logic        result_valid,
  output logic        busy,
  output logic [7:0]  crc_err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MUL_T  = 2'd1;
  localparam logic [1:0] MUL_RH = 2'd2;
  localparam logic [1:0] FINAL  = 2'd3;

  localparam logic [31:0] ROUND_HALF = 32'd32768;
  localparam logic [31:0] T_SCALE    = 32'd17500;
  localparam logic [31:0] RH_SCALE   = 32'd12500;
  localparam logic [15:0] T_OFFSET   = 16'd4500;
  localparam logic [15:0] RH_OFFSET  = 16'd600;
  localparam logic signed [15:0] RH_MAX = 16'sd10000;

  logic        temp_d, rh_d, crc_d;
  logic        temp_rise, rh_rise, crc_rise;
  logic [15:0] temp_hold, rh_hold;
  logic        t_have, rh_have;
  logic [1:0]  state;
  logic [15:0] t_op, rh_op;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic signed [15:0] t_int, rh_int;
  logic        start;
  logic        op_bit;
  logic [31:0] addend;
  logic [31:0] acc_next;
  logic [15:0] scaled;

  assign temp_rise = temp_ready & ~temp_d;
  assign rh_rise   = rh_ready & ~rh_d;
  assign crc_rise  = crc_error & ~crc_d;
  assign start     = (state == IDLE) & t_have & rh_have;
  assign busy      = (state != IDLE);

  // One shift-add step: the current operand bit selects the scale shifted by cnt
  always_comb begin
    op_bit   = (state == MUL_T) ? t_op[cnt] : rh_op[cnt];
    addend   = (state == MUL_T) ? (T_SCALE << cnt) : (RH_SCALE << cnt);
    acc_next = acc + (op_bit ? addend : 32'd0);
    scaled   = acc_next[31:16];
  end

  // Register the ready/error flags for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_d <= 1'b0;
      rh_d   <= 1'b0;
      crc_d  <= 1'b0;
    end else begin
      temp_d <= temp_ready;
      rh_d   <= rh_ready;
      crc_d  <= crc_error;
    end
  end

  // Capture raw words; a CRC failure discards the partial pair and wins over captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_hold     <= 16'd0;
      rh_hold       <= 16'd0;
      t_have        <= 1'b0;
      rh_have       <= 1'b0;
      crc_err_count <= 8'd0;
    end else if (crc_rise) begin
      t_have  <= 1'b0;
      rh_have <= 1'b0;
      if (crc_err_count != 8'hFF) crc_err_count <= crc_err_count + 8'd1;
    end else begin
      if (start) begin
        t_have  <= 1'b0;
        rh_have <= 1'b0;
      end
      if (temp_rise) begin
        temp_hold <= temp_raw;
        t_have    <= 1'b1;
      end
      if (rh_rise) begin
        rh_hold <= rh_raw;
        rh_have <= 1'b1;
      end
    end
  end

  // Conversion sequencer, multiplier datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      t_op         <= 16'd0;
      rh_op        <= 16'd0;
      acc          <= 32'd0;
      cnt          <= 4'd0;
      t_int        <= 16'sd0;
      rh_int       <= 16'sd0;
      temp_centi   <= 16'd0;
      rh_centi     <= 16'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t_op  <= temp_hold;
            rh_op <= rh_hold;
            acc   <= ROUND_HALF;
            cnt   <= 4'd0;
            state <= MUL_T;
          end
        end
        MUL_T: begin
          if (cnt == 4'd15) begin
            t_int <= scaled - T_OFFSET;
            acc   <= ROUND_HALF;
            cnt   <= 4'd0;
            state <= MUL_RH;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 4'd1;
          end
        end
        MUL_RH: begin
          if (cnt == 4'd15) begin
            rh_int <= scaled - RH_OFFSET;
            state  <= FINAL;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          temp_centi <= t_int;
          if (rh_int < 16'sd0)       rh_centi <= 16'd0;
          else if (rh_int > RH_MAX)  rh_centi <= 16'd10000;
          else                       rh_centi <= rh_int;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_result_converter.sv
// Scoreboard bench for sht40_result_converter: stimulus tasks push expected
// result pairs computed arithmetically; a monitor pops them on result_valid.
module tb_sht40_result_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] temp_raw = 16'd0;
  logic [15:0] rh_raw = 16'd0;
  logic        temp_ready = 1'b0;
  logic        rh_ready = 1'b0;
  logic        crc_error = 1'b0;
  logic [15:0] temp_centi;
  logic [15:0] rh_centi;
  logic        result_valid;
  logic        busy;
  logic [7:0]  crc_err_count;

  sht40_result_converter dut (
    .clk(clk), .rst_n(rst_n), .temp_raw(temp_raw), .rh_raw(rh_raw),
    .temp_ready(temp_ready), .rh_ready(rh_ready), .crc_error(crc_error),
    .temp_centi(temp_centi), .rh_centi(rh_centi), .result_valid(result_valid),
    .busy(busy), .crc_err_count(crc_err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_vc = 0;
  int prev_vc = 0;
  int rh_cyc = 0;
  logic prev_rv = 1'b0;

  logic [31:0] sb[$];

  // behavioural model of the capture side
  logic [15:0] m_thold, m_rhold;
  logic        m_th = 1'b0, m_rh = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [31:0] expect_pair(input logic [15:0] t, input logic [15:0] h);
    longint tc, hc;
    logic [15:0] tr, hr;
    tc = (longint'(t) * 17500 + 32768) / 65536 - 4500;
    hc = (longint'(h) * 12500 + 32768) / 65536 - 600;
    if (hc < 0) hc = 0;
    if (hc > 10000) hc = 10000;
    tr = 16'(tc);
    hr = 16'(hc);
    return {tr, hr};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_pair();
    if (m_th && m_rh) begin
      sb.push_back(expect_pair(m_thold, m_rhold));
      m_th = 1'b0;
      m_rh = 1'b0;
    end
  endtask

  task automatic ev_temp(input logic [15:0] v);
    temp_raw = v;
    temp_ready = 1'b1;
    m_thold = v;
    m_th = 1'b1;
    model_pair();
    tick($urandom_range(1, 3));
    temp_ready = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic ev_rh(input logic [15:0] v);
    rh_raw = v;
    rh_ready = 1'b1;
    rh_cyc = cyc;
    m_rhold = v;
    m_rh = 1'b1;
    model_pair();
    tick($urandom_range(1, 3));
    rh_ready = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic ev_crc(input int hi, input int gap);
    crc_error = 1'b1;
    m_th = 1'b0;
    m_rh = 1'b0;
    if (m_cnt < 255) m_cnt++;
    tick(hi);
    crc_error = 1'b0;
    tick(gap);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
      sb.delete();
    end
    tick(2);
  endtask

  function automatic logic [15:0] rnd16();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  // Monitor: every result_valid pops one expected pair
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && result_valid) begin
      prev_vc = last_vc;
      last_vc = cyc;
      chk("valid_not_consecutive", {31'd0, prev_rv}, 32'd0);
      chk("busy_low_on_valid", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got temp=%0d rh=%0d, required no result", temp_centi, rh_centi);
      end else begin
        e = sb.pop_front();
        chk("temp_centi", {16'd0, temp_centi}, {16'd0, e[31:16]});
        chk("rh_centi", {16'd0, rh_centi}, {16'd0, e[15:0]});
      end
    end
    prev_rv = rst_n & result_valid;
  end

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    chk("reset_temp", {16'd0, temp_centi}, 32'd0);
    chk("reset_rh", {16'd0, rh_centi}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_crc_count", {24'd0, crc_err_count}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // nominal pair and latency from rh capture
    ev_temp(16'h6666);
    ev_rh(16'h8000);
    chk("busy_during_conversion", {31'd0, busy}, 32'd1);
    chk("nominal_expected", sb[0], {16'd2500, 16'd5650});
    wait_drain(60);
    chk("latency_rh_to_valid", 32'(last_vc - rh_cyc), 32'd35);

    // extremes
    ev_temp(16'h0000);
    ev_rh(16'h0000);
    wait_drain(60);
    chk("low_extreme_temp", {16'd0, temp_centi}, 32'h0000EE6C);
    ev_temp(16'hFFFF);
    ev_rh(16'hFFFF);
    wait_drain(60);
    chk("high_extreme_temp", {16'd0, temp_centi}, 32'd13000);
    chk("high_extreme_rh", {16'd0, rh_centi}, 32'd10000);

    // CRC discard then completion by a fresh temp
    ev_temp(16'h1234);
    ev_crc(1, 2);
    ev_rh(16'h4321);
    tick(45);
    chk("crc_discard_count", {24'd0, crc_err_count}, 32'(m_cnt));
    chk("crc_discard_count_is_1", {24'd0, crc_err_count}, 32'd1);
    ev_temp(16'h5A5A);
    wait_drain(60);

    // simultaneous crc and temp rise: no capture
    temp_raw = 16'h7777;
    temp_ready = 1'b1;
    crc_error = 1'b1;
    m_th = 1'b0;
    m_rh = 1'b0;
    m_cnt++;
    tick(1);
    temp_ready = 1'b0;
    crc_error = 1'b0;
    tick(2);
    ev_rh(16'h3000);
    tick(45);
    chk("simul_crc_count", {24'd0, crc_err_count}, 32'd2);
    ev_temp(16'h2000);
    wait_drain(60);

    // two temps before rh: latest wins
    ev_temp(16'h1111);
    ev_temp(16'hC000);
    ev_rh(16'h9999);
    wait_drain(60);

    // randomized transactions
    for (int it = 0; it < 30; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            ev_temp(rnd16()); ev_rh(rnd16());
          end else begin
            ev_rh(rnd16()); ev_temp(rnd16());
          end
        end
        1: begin
          ev_temp(rnd16()); ev_temp(rnd16()); ev_rh(rnd16());
        end
        2: begin
          ev_temp(rnd16()); ev_crc(1, 1); ev_rh(rnd16());
          tick(40);
          ev_temp(rnd16());
        end
        default: begin
          ev_temp(rnd16()); ev_rh(rnd16());
          tick($urandom_range(1, 8));
          ev_rh(rnd16()); ev_temp(rnd16());
        end
      endcase
      wait_drain(150);
      if (kind == 3) chk("back_to_back_spacing", 32'(last_vc - prev_vc), 32'd34);
      chk("rand_crc_count", {24'd0, crc_err_count}, 32'(m_cnt));
    end

    // saturation
    for (int i = 0; i < 300; i++) ev_crc(1, 1);
    chk("crc_saturation", {24'd0, crc_err_count}, 32'd255);

    // reset in the middle of MUL_RH
    ev_temp(16'hABCD);
    ev_rh(16'h6000);
    tick(20 - $urandom_range(0, 4));
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_temp", {16'd0, temp_centi}, 32'd0);
    chk("async_reset_rh", {16'd0, rh_centi}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_count", {24'd0, crc_err_count}, 32'd0);
    sb.delete();
    m_th = 1'b0;
    m_rh = 1'b0;
    m_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    ev_temp(16'h6666);
    ev_rh(16'h8000);
    wait_drain(60);
    chk("post_reset_temp", {16'd0, temp_centi}, 32'd2500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
